// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encodings, defaults and
// the parity helper used when checking the optional parity bit.
package uart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_START  = ST_START,
      S_DATA   = ST_DATA,
      S_PARITY = ST_PARITY,
      S_STOP   = ST_STOP,
      S_DONE   = ST_DONE
   } rx_state_t;

   localparam int DEF_CLKS_PER_BIT = 16;
   localparam int DEF_DATA_BITS    = 8;

   // Expected parity bit for a zero-extended data word.
   function automatic logic parity_of(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_fsm_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect used to
// recognise the leading edge of a start bit.
module rx_sync
   import uart_pkg::*;
(
   input  logic clka,
   input  logic reset,
   input  logic rx,
   output logic rx_s,
   output logic start_edge
);

   logic sync_p0;
   logic sync_p1;
   logic prev_p2;

   // All three flops reset to the idle-high line level so no edge fires at release.
   always_ff @(posedge clka or negedge reset) begin
      if (!reset) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
         prev_p2 <= 1'b1;
      end else begin
         sync_p0 <= rx;
         sync_p1 <= sync_p0;
         prev_p2 <= sync_p1;
      end
   end

   assign rx_s       = sync_p1;
   assign start_edge = prev_p2 & ~sync_p1;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: mid-bit sampling FSM with baud counter, LSB-first shift
// register, optional parity check and a valid/ack output handshake.
module uart_rx_fsm
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEF_DATA_BITS,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       clka,
   input  logic       reset,
   input  logic       rx,
   input  logic       rx_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_parity_err,
   output logic       rx_frame_err,
   output logic       rx_overrun,
   output logic       rx_busy,
   output logic       rx_idle,
   output logic [2:0] rstate,
   output logic [3:0] rcount
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [3:0]       LAST_BIT      = 4'(DATA_BITS - 1);

   generate
      if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
         $error("uart_rx_fsm: CLKS_PER_BIT must be even and >= 4");
      end
      if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
         $error("uart_rx_fsm: DATA_BITS must be in 5..8");
      end
   endgenerate

   rx_state_t            state;
   logic [CNT_W-1:0]     baud_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 par_err_pend;
   logic                 frm_err_pend;
   logic                 rx_s;
   logic                 start_edge;
   logic                 bit_tick;
   logic                 ack_take;

   rx_sync u_sync (
      .clka       (clka),
      .reset      (reset),
      .rx         (rx),
      .rx_s       (rx_s),
      .start_edge (start_edge)
   );

   assign bit_tick = (baud_cnt == CNT_BIT_LAST);
   assign ack_take = rx_ack & rx_valid;
   assign rstate   = state;

   always_ff @(posedge clka or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         baud_cnt      <= '0;
         shift_reg     <= '0;
         par_err_pend  <= 1'b0;
         frm_err_pend  <= 1'b0;
         rcount        <= 4'd0;
         rx_data       <= 8'd0;
         rx_valid      <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_overrun    <= 1'b0;
         rx_busy       <= 1'b0;
         rx_idle       <= 1'b1;
      end else begin
         // The ack clears the presented byte; a DONE load below overrides it.
         if (ack_take) begin
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (start_edge) begin
                  state        <= S_START;
                  baud_cnt     <= '0;
                  rcount       <= 4'd0;
                  par_err_pend <= 1'b0;
                  frm_err_pend <= 1'b0;
                  rx_busy      <= 1'b1;
                  rx_idle      <= 1'b0;
               end
            end

            S_START: begin
               if (baud_cnt == CNT_HALF_LAST) begin
                  baud_cnt <= '0;
                  if (!rx_s) begin
                     state <= S_DATA;
                  end else begin
                     state   <= S_IDLE;
                     rx_busy <= 1'b0;
                     rx_idle <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (bit_tick) begin
                  baud_cnt  <= '0;
                  shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                  rcount    <= rcount + 4'd1;
                  if (rcount == LAST_BIT) begin
                     state <= PARITY_EN ? S_PARITY : S_STOP;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            S_PARITY: begin
               if (bit_tick) begin
                  baud_cnt <= '0;
                  if (rx_s != parity_of(8'(shift_reg), PARITY_ODD)) begin
                     par_err_pend <= 1'b1;
                  end
                  state <= S_STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            S_STOP: begin
               if (bit_tick) begin
                  baud_cnt <= '0;
                  if (!rx_s) begin
                     frm_err_pend <= 1'b1;
                  end
                  state <= S_DONE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            S_DONE: begin
               state   <= S_IDLE;
               rx_busy <= 1'b0;
               rx_idle <= 1'b1;
               if (!rx_valid || rx_ack) begin
                  rx_data       <= 8'(shift_reg);
                  rx_parity_err <= par_err_pend;
                  rx_frame_err  <= frm_err_pend;
                  rx_valid      <= 1'b1;
               end else begin
                  rx_overrun <= 1'b1;
               end
            end

            default: begin
               state   <= S_IDLE;
               rx_busy <= 1'b0;
               rx_idle <= 1'b1;
            end
         endcase
      end
   end

endmodule
